// File: rtl/ring_inject_sched.sv
// Ring injection scheduler: per-FU result FIFOs feeding ring stops, round-robin
// arbitration of up to MAX_INJ injections per cycle. Optional macro RING_INJ_BYPASS_EN.

module ring_inj_fifo #(
  parameter int ENT_W = 48,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [ENT_W-1:0] wdata,
  output logic [ENT_W-1:0] rdata,
  output logic [OCC_W-1:0] occ,
  output logic             empty,
  output logic             full
);
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= wdata;
  end

  assign rdata = r_mem[r_rp];
  assign occ   = r_occ;
  assign empty = (r_occ == '0);
  assign full  = (r_occ == OCC_W'(DEPTH));
endmodule

module ring_inject_sched #(
  parameter int XLEN       = 32,
  parameter int PREG_W     = 8,
  parameter int ROB_W      = 8,
  parameter int NUM_FU     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_INJ    = 2,
  localparam int ENT_W     = PREG_W + XLEN + ROB_W,
  localparam int OCC_W     = $clog2(FIFO_DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  output logic [NUM_FU-1:0]       fu_ready,
  input  logic [NUM_FU*ENT_W-1:0] fu_data,
  input  logic [NUM_FU-1:0]       slot_busy,
  output logic [NUM_FU-1:0]       inj_valid,
  output logic [NUM_FU*ENT_W-1:0] inj_data,
  output logic [NUM_FU*OCC_W-1:0] occ
);
  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0][ENT_W-1:0] w_fu_data, w_rdata, w_head, r_inj_data;
  logic [NUM_FU-1:0][OCC_W-1:0] w_occ;
  logic [NUM_FU-1:0] w_empty, w_full, w_push, w_byp, w_elig, w_grant;
  logic [NUM_FU-1:0] w_fifo_push, w_fifo_pop, r_inj_valid;
  logic [RR_W-1:0]   r_rr, w_rr_nxt, w_idx;
  logic [RR_W:0]     w_sum;
  int                w_cnt;

  assign w_fu_data = fu_data;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // No look-through: a full FIFO refuses even when its head pops this cycle.
    assign fu_ready[i] = ~w_full[i] & ~flush & ~rst;
    assign w_push[i]   = fu_valid[i] & fu_ready[i];
`ifdef RING_INJ_BYPASS_EN
    assign w_byp[i]    = w_empty[i] & w_push[i];
`else
    assign w_byp[i]    = 1'b0;
`endif
    assign w_elig[i]      = (~w_empty[i] | w_byp[i]) & ~slot_busy[i] & ~flush;
    assign w_head[i]      = w_empty[i] ? w_fu_data[i] : w_rdata[i];
    assign w_fifo_pop[i]  = w_grant[i] & ~w_empty[i];
    assign w_fifo_push[i] = w_push[i] & ~(w_grant[i] & w_empty[i]);

    ring_inj_fifo #(.ENT_W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (w_fifo_push[i]),
      .pop   (w_fifo_pop[i]),
      .wdata (w_fu_data[i]),
      .rdata (w_rdata[i]),
      .occ   (w_occ[i]),
      .empty (w_empty[i]),
      .full  (w_full[i])
    );
  end

  // Scan from r_rr around the ring, granting the first MAX_INJ eligible stops.
  always_comb begin
    w_grant  = '0;
    w_rr_nxt = r_rr;
    w_cnt    = 0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_sum = {1'b0, r_rr} + (RR_W+1)'(k);
      if (w_sum >= (RR_W+1)'(NUM_FU)) w_sum = w_sum - (RR_W+1)'(NUM_FU);
      w_idx = w_sum[RR_W-1:0];
      if (w_elig[w_idx] && (w_cnt < MAX_INJ)) begin
        w_grant[w_idx] = 1'b1;
        w_cnt          = w_cnt + 1;
        w_rr_nxt       = (w_idx == RR_W'(NUM_FU-1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_valid <= '0;
      r_inj_data  <= '0;
      r_rr        <= '0;
    end else if (flush) begin
      r_inj_valid <= '0;
      r_rr        <= '0;
    end else begin
      r_inj_valid <= w_grant;
      r_rr        <= w_rr_nxt;
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_grant[i]) r_inj_data[i] <= w_head[i];
      end
    end
  end

  assign inj_valid = r_inj_valid;
  assign inj_data  = r_inj_data;
  assign occ       = w_occ;
endmodule

// File: tb/tb_ring_inject_sched.sv
// Randomized + directed bench for ring_inject_sched against a queue-based model.
module tb_ring_inject_sched;
  localparam int XLEN = 32, PREG_W = 8, ROB_W = 8, NUM_FU = 5, DEPTH = 4, MAX_INJ = 2;
  localparam int ENT_W = PREG_W + XLEN + ROB_W;
  localparam int OCC_W = $clog2(DEPTH+1);
`ifdef RING_INJ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef logic [ENT_W-1:0] ent_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [NUM_FU-1:0]       fu_valid = '0, slot_busy = '0, fu_ready, inj_valid;
  logic [NUM_FU*ENT_W-1:0] fu_data = '0, inj_data;
  logic [NUM_FU*OCC_W-1:0] occ;

  ring_inject_sched #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W), .NUM_FU(NUM_FU),
                      .FIFO_DEPTH(DEPTH), .MAX_INJ(MAX_INJ)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_data(fu_data), .slot_busy(slot_busy), .inj_valid(inj_valid),
    .inj_data(inj_data), .occ(occ)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  ent_t q [NUM_FU][$];
  ent_t din [NUM_FU];
  ent_t m_dat [NUM_FU];
  logic [NUM_FU-1:0] m_vld = '0, m_rdy, m_push;
  int m_rr = 0;
  bit keep_din = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check shortly after, then advance the model.
  task automatic tick(input logic [NUM_FU-1:0] v, input logic [NUM_FU-1:0] b,
                      input logic fl, input logic r);
    logic [NUM_FU-1:0] nv;
    ent_t nd [NUM_FU];
    int cnt, last, idx;
    @(negedge clk);
    if (!keep_din)
      for (int i = 0; i < NUM_FU; i++) din[i] = {8'($urandom), 32'($urandom), 8'($urandom)};
    fu_valid = v; slot_busy = b; flush = fl; rst = r;
    for (int i = 0; i < NUM_FU; i++) fu_data[i*ENT_W +: ENT_W] = din[i];
    #1;
    if (r) begin
      for (int i = 0; i < NUM_FU; i++) begin q[i].delete(); m_dat[i] = '0; end
      m_vld = '0; m_rr = 0;
      chk("rst_data", 64'(|inj_data), 64'd0);
    end
    for (int i = 0; i < NUM_FU; i++) m_rdy[i] = !r && !fl && (q[i].size() < DEPTH);
    chk("fu_ready", 64'(fu_ready), 64'(m_rdy));
    chk("inj_valid", 64'(inj_valid), 64'(m_vld));
    for (int i = 0; i < NUM_FU; i++) begin
      chk($sformatf("occ%0d", i), 64'(occ[i*OCC_W +: OCC_W]), 64'(q[i].size()));
      if (m_vld[i]) chk($sformatf("inj_data%0d", i), 64'(inj_data[i*ENT_W +: ENT_W]), 64'(m_dat[i]));
    end
    m_push = v & m_rdy;
    if (r) return;
    if (fl) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      m_vld = '0; m_rr = 0;
      return;
    end
    nv = '0; cnt = 0; last = -1;
    for (int i = 0; i < NUM_FU; i++) nd[i] = m_dat[i];
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (m_rr + k) % NUM_FU;
      if ((q[idx].size() > 0 || (BYP && m_push[idx])) && !b[idx] && cnt < MAX_INJ) begin
        nv[idx] = 1'b1; cnt++; last = idx;
        if (q[idx].size() > 0) nd[idx] = q[idx].pop_front();
        else begin nd[idx] = din[idx]; m_push[idx] = 1'b0; end
      end
    end
    for (int i = 0; i < NUM_FU; i++) if (m_push[i]) q[i].push_back(din[i]);
    m_vld = nv;
    for (int i = 0; i < NUM_FU; i++) m_dat[i] = nd[i];
    if (last >= 0) m_rr = (last + 1) % NUM_FU;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) tick('0, '0, 1'b0, 1'b0);
  endtask

  task automatic fu2_beef();
    keep_din = 1'b1;
    din[2] = {8'h12, 32'hDEADBEEF, 8'h34};
    tick(5'b00100, '0, 1'b0, 1'b0);
    keep_din = 1'b0;
    idle(4);
  endtask

  initial begin
    int sent;
    // reset state
    tick('0, '0, 1'b0, 1'b1);
    tick(5'b11111, '0, 1'b0, 1'b1);
    idle(2);
    // single FU2 result, latency and drain
    fu2_beef();
    // all FUs at once, MAX_INJ per cycle in round-robin order
    tick(5'b11111, '0, 1'b0, 1'b0);
    idle(5);
    // stop 1 blocked while FU1 overfills, then drains in order
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      tick((sent < 5) ? 5'b00010 : 5'b00000, 5'b00010, 1'b0, 1'b0);
      if (m_push[1]) sent++;
    end
    chk("r21_occ_full", 64'(occ[1*OCC_W +: OCC_W]), 64'(DEPTH));
    for (int c = 0; c < 10; c++) begin
      tick((sent < 5) ? 5'b00010 : 5'b00000, '0, 1'b0, 1'b0);
      if (m_push[1]) sent++;
    end
    chk("r21_sent", 64'(sent), 64'd5);
    // FIFO 3 full, push attempted while head pops
    for (int c = 0; c < 4; c++) tick(5'b01000, 5'b01000, 1'b0, 1'b0);
    tick(5'b01000, '0, 1'b0, 1'b0);
    chk("r22_rdy_full", 64'(fu_ready[3]), 64'd0);
    tick('0, 5'b01000, 1'b0, 1'b0);
    chk("r22_occ3", 64'(occ[3*OCC_W +: OCC_W]), 64'd3);
    chk("r22_rdy_back", 64'(fu_ready[3]), 64'd1);
    idle(6);
    // flush with three entries per FU
    for (int c = 0; c < 3; c++) tick(5'b11111, 5'b11111, 1'b0, 1'b0);
    tick(5'b11111, '0, 1'b1, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    chk("r23_occ", 64'(occ), 64'd0);
    chk("r23_vld", 64'(inj_valid), 64'd0);
    idle(4);
    // rr pointer back at 0 after flush: all FUs push, FU0/FU1 win first
    tick(5'b11111, '0, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    chk("r23_rr0", 64'(inj_valid), BYP ? 64'h0c : 64'h03);
    idle(4);
    // async reset mid-burst
    for (int c = 0; c < 3; c++) tick(5'b11111, 5'b00101, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    chk("r24_vld", 64'(inj_valid), 64'd0);
    chk("r24_occ", 64'(occ), 64'd0);
    chk("r24_data", 64'(|inj_data), 64'd0);
    tick(5'b11111, '0, 1'b0, 1'b1);
    tick('0, '0, 1'b0, 1'b0);
    chk("r24_rdy", 64'(fu_ready), 64'h1f);
    fu2_beef();
    // random traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      tick(NUM_FU'($urandom), NUM_FU'($urandom & $urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(8);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
